// File: rtl/divider_pkg.sv
// Shared state encoding and default widths for the restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DIVISOR_W_DEF  = 6;
  localparam int unsigned DIVIDEND_W_DEF = 12;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DIVISOR_W = 6
) (
  input  logic [DIVISOR_W-1:0] i_part,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_div,
  output logic [DIVISOR_W-1:0] o_part,
  output logic                 o_qbit
);

  logic [DIVISOR_W:0]   w_shift;
  logic [DIVISOR_W+1:0] w_diff;

  // Extra top bit of the difference acts as the borrow/sign.
  always_comb begin
    w_shift = {i_part, i_bit};
    w_diff  = {1'b0, w_shift} - {2'b00, i_div};
    o_qbit  = ~w_diff[DIVISOR_W+1];
    o_part  = DIVISOR_W'(o_qbit ? w_diff : {1'b0, w_shift});
  end

endmodule

// File: rtl/divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF,
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  output logic [DIVIDEND_W-1:0] quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_div;
  logic [DIVISOR_W-1:0]  r_part;

  logic [DIVISOR_W-1:0]  w_part_next;
  logic                  w_qbit;
  logic [DIVIDEND_W-1:0] w_dvd_next;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .i_part (r_part),
    .i_bit  (r_dvd[DIVIDEND_W-1]),
    .i_div  (r_div),
    .o_part (w_part_next),
    .o_qbit (w_qbit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign w_dvd_next = {r_dvd[DIVIDEND_W-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      r_part  <= '0;
      quot    <= '0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start) begin
            if (b != '0) begin
              r_dvd   <= a;
              r_div   <= b;
              r_part  <= '0;
              r_cnt   <= CNT_W'(DIVIDEND_W);
              busy    <= 1'b1;
              r_state <= S_RUN;
            end else begin
              quot    <= '1;
              rem     <= '0;
              dbz     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_dvd  <= w_dvd_next;
          r_part <= w_part_next;
          r_cnt  <= r_cnt - CNT_W'(1);
          // Last step: publish the finished quotient and remainder together.
          if (r_cnt == CNT_W'(1)) begin
            quot    <= w_dvd_next;
            rem     <= w_part_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            dbz     <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
